// File: rtl/bp_pkg.sv
// Shared encodings and next-state logic for the 2-bit branch history counters.
// Latency: n/a (pure definitions). Backpressure: n/a.
// Contents: counter state encodings, reset state, saturating next-state helper.
package bp_pkg;

    localparam logic [1:0] SNT       = 2'b00;  // strongly not-taken
    localparam logic [1:0] WNT       = 2'b01;  // weakly not-taken
    localparam logic [1:0] WT        = 2'b10;  // weakly taken
    localparam logic [1:0] ST        = 2'b11;  // strongly taken
    localparam logic [1:0] BHT_RESET = WNT;

    // Saturating step toward the resolved direction.
    function automatic logic [1:0] sat2_next(input logic [1:0] state, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (state == ST) ? ST : state + 2'd1;
        end else begin
            nxt = (state == SNT) ? SNT : state - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter_2b.sv
// One 2-bit saturating branch history entry.
// Latency: new state visible the cycle after an enabled edge.
// Backpressure: none; holds its value whenever i_en is low.
// Ports: clk, rst_n (sync, active-low -> BHT_RESET), i_en (train this entry),
//        i_taken (resolved direction), o_state (current 2-bit state).
module sat_counter_2b
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_taken,
    output logic [1:0] o_state
);

    logic [1:0] r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BHT_RESET;
        end else if (i_en) begin
            r_state <= sat2_next(r_state, i_taken);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/branch_predictor_bht.sv
// Untagged 2-bit saturating-counter BHT with misprediction flag and perf counters.
// Latency: lookup 0 cycles (combinational), training visible 1 cycle after the edge.
// Backpressure: stall freezes table and counters; mispredict stays live during stall.
// Ports: clk, rst_n (sync, active-low); stall; lookup_pc -> predict_taken;
//        update_valid/update_pc/actual_taken/predicted_taken_ex -> mispredict;
//        branch_count, mispredict_count (free-running, wrapping).
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int XLEN     = 32,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             predict_taken,
    input  logic             update_valid,
    input  logic [XLEN-1:0]  update_pc,
    input  logic             actual_taken,
    input  logic             predicted_taken_ex,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [IDX_BITS-1:0]          w_lookup_idx;
    logic [IDX_BITS-1:0]          w_upd_idx;
    logic [1:0]                   w_state [ENTRIES];
    logic                         w_do_upd;
    logic                         w_mispredict;
    // Byte-offset and above-index PC bits carry no information for an untagged table.
    logic [2*(XLEN-IDX_BITS)-1:0] w_unused_pc_bits;

    logic [CNT_W-1:0]             r_branch_count;
    logic [CNT_W-1:0]             r_mispredict_count;

    assign w_lookup_idx     = lookup_pc[IDX_BITS+1:2];
    assign w_upd_idx        = update_pc[IDX_BITS+1:2];
    assign w_unused_pc_bits = {lookup_pc[XLEN-1:IDX_BITS+2], lookup_pc[1:0],
                               update_pc[XLEN-1:IDX_BITS+2], update_pc[1:0]};

    assign w_do_upd     = update_valid & ~stall & rst_n;
    // Not gated by stall: flush logic must see the mispredict while EX is held.
    assign w_mispredict = rst_n & update_valid & (actual_taken != predicted_taken_ex);

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        sat_counter_2b u_ctr (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_do_upd && (w_upd_idx == IDX_BITS'(i))),
            .i_taken (actual_taken),
            .o_state (w_state[i])
        );
    end

    // Reads the registered state, so a same-cycle update to this index is not bypassed.
    assign predict_taken = rst_n & w_state[w_lookup_idx][1];
    assign mispredict    = w_mispredict;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_do_upd) begin
            r_branch_count <= r_branch_count + CNT_W'(1);
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic        predicted_taken_ex;
    logic        mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_predictor_bht #(.IDX_BITS(4), .XLEN(32), .CNT_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .lookup_pc          (lookup_pc),
        .predict_taken      (predict_taken),
        .update_valid       (update_valid),
        .update_pc          (update_pc),
        .actual_taken       (actual_taken),
        .predicted_taken_ex (predicted_taken_ex),
        .mispredict         (mispredict),
        .branch_count       (branch_count),
        .mispredict_count   (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        act;
        logic        pex;
        logic [31:0] lpc;
        logic        e_pred;
        logic        e_misp;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs are changed 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic uv, input logic [31:0] upc, input logic act, input logic pex);
        update_valid       = uv;
        update_pc          = upc;
        actual_taken       = act;
        predicted_taken_ex = pex;
    endtask

    initial begin
        // Inputs are applied, outputs checked 1 unit later (pre-edge values), then the edge.
        //            uv    upc     act   pex   lpc     pred  misp  bc  mc
        vecs[0]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 1'b1, 0, 0}; // WNT->WT
        vecs[1]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 1, 1}; // WT->ST
        vecs[2]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 2, 2}; // ST holds
        vecs[3]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 3, 3}; // ST->WT
        vecs[4]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 4, 3}; // WT->WNT
        vecs[5]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 5, 3}; // WNT->SNT
        vecs[6]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 6, 3}; // SNT holds
        vecs[7]  = '{1'b0, 32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 7, 3}; // no valid: ignored
        vecs[8]  = '{1'b0, 32'h40, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 7, 3}; // alias idx0, no underflow
        vecs[9]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 7, 3}; // mispredict other way
        vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 8, 4};
        vecs[11] = '{1'b1, 32'h08, 1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 8, 4}; // no bypass
        vecs[12] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h48, 1'b1, 1'b0, 9, 4}; // visible next cycle
        vecs[13] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h04, 1'b0, 1'b0, 9, 4}; // idx1 untouched
        vecs[14] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h4B, 1'b1, 1'b0, 9, 4}; // pc[1:0] ignored

        rst_n     = 1'b0;
        stall     = 1'b0;
        lookup_pc = 32'h0;
        set_upd(1'b1, 32'h14, 1'b1, 1'b0);

        // Reset held 2 cycles; outputs forced low even with a mismatching update presented.
        cyc();
        chk("rst_predict", {31'b0, predict_taken}, 32'd0);
        chk("rst_mispredict", {31'b0, mispredict}, 32'd0);
        cyc();
        rst_n = 1'b1;
        set_upd(1'b0, 32'h0, 1'b0, 1'b0);
        for (int pc = 0; pc <= 32'h3C; pc += 4) begin
            lookup_pc = 32'(pc);
            #1;
            chk($sformatf("rst_sweep_%0h", pc), {31'b0, predict_taken}, 32'd0);
        end
        chk("rst_bc", branch_count, 32'd0);
        chk("rst_mc", mispredict_count, 32'd0);
        cyc();

        for (int v = 0; v < 15; v++) begin
            set_upd(vecs[v].uv, vecs[v].upc, vecs[v].act, vecs[v].pex);
            lookup_pc = vecs[v].lpc;
            #1;
            chk($sformatf("v%0d_pred", v), {31'b0, predict_taken}, {31'b0, vecs[v].e_pred});
            chk($sformatf("v%0d_misp", v), {31'b0, mispredict}, {31'b0, vecs[v].e_misp});
            chk($sformatf("v%0d_bc", v), branch_count, vecs[v].e_bc);
            chk($sformatf("v%0d_mc", v), mispredict_count, vecs[v].e_mc);
            cyc();
        end

        // Stall hold at idx3: 5 stalled cycles, then one live edge.
        set_upd(1'b1, 32'h0C, 1'b1, 1'b0);
        lookup_pc = 32'h0C;
        stall     = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("stall%0d_misp", s), {31'b0, mispredict}, 32'd1);
            chk($sformatf("stall%0d_pred", s), {31'b0, predict_taken}, 32'd0);
            chk($sformatf("stall%0d_bc", s), branch_count, 32'd9);
            cyc();
        end
        stall = 1'b0;
        #1;
        chk("unstall_misp", {31'b0, mispredict}, 32'd1);
        cyc();
        set_upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("unstall_pred", {31'b0, predict_taken}, 32'd1);
        chk("unstall_bc", branch_count, 32'd10);
        chk("unstall_mc", mispredict_count, 32'd5);
        // One not-taken step must land on WNT if only a single increment happened.
        set_upd(1'b1, 32'h0C, 1'b0, 1'b0);
        cyc();
        set_upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("single_inc_pred", {31'b0, predict_taken}, 32'd0);
        chk("single_inc_bc", branch_count, 32'd11);

        // Reset coincident with a taken update at idx4.
        set_upd(1'b1, 32'h10, 1'b1, 1'b0);
        lookup_pc = 32'h48;
        rst_n     = 1'b0;
        #1;
        chk("midrst_pred_forced", {31'b0, predict_taken}, 32'd0);
        chk("midrst_misp_forced", {31'b0, mispredict}, 32'd0);
        cyc();
        rst_n = 1'b1;
        set_upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("midrst_idx2_pred", {31'b0, predict_taken}, 32'd0);
        lookup_pc = 32'h10;
        #1;
        chk("midrst_idx4_pred", {31'b0, predict_taken}, 32'd0);
        chk("midrst_bc", branch_count, 32'd0);
        chk("midrst_mc", mispredict_count, 32'd0);
        // Lost update => idx4 is WNT: not-taken then taken ends at WNT (predict 0).
        set_upd(1'b1, 32'h10, 1'b0, 1'b0);
        cyc();
        set_upd(1'b1, 32'h10, 1'b1, 1'b0);
        cyc();
        set_upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("midrst_lost_pred", {31'b0, predict_taken}, 32'd0);
        chk("midrst_after_bc", branch_count, 32'd2);
        chk("midrst_after_mc", mispredict_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
